// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, bus FSM state type and width limit shared by gpio_ctrl.
// Addresses 6/7 are decoded only when GPIO_ATOMIC_SETCLR_EN is defined.
package gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;

    localparam int GPIO_ADDR_DATA_OUT   = 0;
    localparam int GPIO_ADDR_OE         = 1;
    localparam int GPIO_ADDR_DATA_IN    = 2;
    localparam int GPIO_ADDR_IRQ_EN     = 3;
    localparam int GPIO_ADDR_IRQ_TYPE   = 4;
    localparam int GPIO_ADDR_IRQ_STATUS = 5;
    localparam int GPIO_ADDR_DATA_SET   = 6;
    localparam int GPIO_ADDR_DATA_CLR   = 7;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } gpio_ctrl_state_t;

endpackage

// File: rtl/gpio_in_sync.sv
// gpio_in_sync: 2-flop synchronizer for asynchronous pad inputs plus a history
// flop used to detect rising and falling edges on the synchronized value.
module gpio_in_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH = GPIO_MAX_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: req/ack register-mapped GPIO controller with synchronized readback
// and per-pin edge interrupts. Define GPIO_ATOMIC_SETCLR_EN for DATA_SET/DATA_CLR.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ack,
    output logic              bus_err,
    output logic [WIDTH-1:0]  gpio_data_out,
    output logic [WIDTH-1:0]  gpio_oe,
    input  logic [WIDTH-1:0]  gpio_data_in,
    output logic              irq
);

    gpio_ctrl_state_t r_state;
    gpio_ctrl_state_t w_state_nxt;

    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_oe;
    logic [WIDTH-1:0] r_en;
    logic [WIDTH-1:0] r_type;
    logic [WIDTH-1:0] r_status;
    logic [31:0]      r_rdata;
    logic             r_ack;
    logic             r_err;
    logic             r_irq;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_dout_nxt;
    logic [WIDTH-1:0] w_w1c;
    logic [31:0]      w_rd_val;
    logic             w_access;
    logic             w_wr;
    logic             w_mapped;
    logic             w_sel_dout;
    logic             w_sel_oe;
    logic             w_sel_din;
    logic             w_sel_en;
    logic             w_sel_type;
    logic             w_sel_status;

    gpio_in_sync #(.WIDTH(WIDTH)) u_in_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .i_data  (gpio_data_in),
        .o_sync  (w_sync),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_sel_dout   = bus_addr == ADDR_W'(GPIO_ADDR_DATA_OUT);
    assign w_sel_oe     = bus_addr == ADDR_W'(GPIO_ADDR_OE);
    assign w_sel_din    = bus_addr == ADDR_W'(GPIO_ADDR_DATA_IN);
    assign w_sel_en     = bus_addr == ADDR_W'(GPIO_ADDR_IRQ_EN);
    assign w_sel_type   = bus_addr == ADDR_W'(GPIO_ADDR_IRQ_TYPE);
    assign w_sel_status = bus_addr == ADDR_W'(GPIO_ADDR_IRQ_STATUS);

    assign w_access = r_state == ACCESS;
    assign w_wr     = w_access && bus_we;
    assign w_wdata  = bus_wdata[WIDTH-1:0];
    assign w_w1c    = (w_wr && w_sel_status) ? w_wdata : '0;
    assign w_edge   = (r_type & w_rise) | (~r_type & w_fall);

`ifdef GPIO_ATOMIC_SETCLR_EN
    logic w_sel_set;
    logic w_sel_clr;
    assign w_sel_set  = bus_addr == ADDR_W'(GPIO_ADDR_DATA_SET);
    assign w_sel_clr  = bus_addr == ADDR_W'(GPIO_ADDR_DATA_CLR);
    assign w_mapped   = w_sel_dout | w_sel_oe | w_sel_din | w_sel_en | w_sel_type
                      | w_sel_status | w_sel_set | w_sel_clr;
    assign w_dout_nxt = w_sel_dout ? w_wdata :
                        w_sel_set  ? (r_dout | w_wdata) :
                        w_sel_clr  ? (r_dout & ~w_wdata) : r_dout;
`else
    assign w_mapped   = w_sel_dout | w_sel_oe | w_sel_din | w_sel_en | w_sel_type
                      | w_sel_status;
    assign w_dout_nxt = w_sel_dout ? w_wdata : r_dout;
`endif

    // Write-only and unmapped addresses fall through to zero.
    always_comb begin
        w_rd_val = w_sel_dout   ? GPIO_MAX_WIDTH'(r_dout)   :
                   w_sel_oe     ? GPIO_MAX_WIDTH'(r_oe)     :
                   w_sel_din    ? GPIO_MAX_WIDTH'(w_sync)   :
                   w_sel_en     ? GPIO_MAX_WIDTH'(r_en)     :
                   w_sel_type   ? GPIO_MAX_WIDTH'(r_type)   :
                   w_sel_status ? GPIO_MAX_WIDTH'(r_status) : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = bus_req ? ACCESS : IDLE;
            ACCESS:  w_state_nxt = ACK;
            ACK:     w_state_nxt = bus_req ? ACK : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= (r_state == ACK) && bus_req;
            if (w_access) begin
                r_err   <= !w_mapped;
                r_rdata <= bus_we ? '0 : w_rd_val;
            end else if (r_state == ACK && !bus_req) begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

    // A new edge in the same cycle as a W1C of that bit keeps the bit set.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_dout   <= '0;
            r_oe     <= '0;
            r_en     <= '0;
            r_type   <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr) r_dout <= w_dout_nxt;
            if (w_wr && w_sel_oe) r_oe <= w_wdata;
            if (w_wr && w_sel_en) r_en <= w_wdata;
            if (w_wr && w_sel_type) r_type <= w_wdata;
            r_status <= (r_status & ~w_w1c) | (w_edge & r_en);
            r_irq    <= |(r_status & r_en);
        end
    end

    assign bus_ack       = r_ack;
    assign bus_err       = r_err & r_ack;
    assign bus_rdata     = r_rdata;
    assign gpio_data_out = r_dout;
    assign gpio_oe       = r_oe;
    assign irq           = r_irq;

endmodule

// File: doc/gpio_ctrl.md
Name:
gpio_ctrl

Overview:
- Register-mapped controller that owns the GPIO pad interface's `gpio_data_out` / `gpio_oe` controls and samples its `gpio_data_in` return path.
- Sits between a simple 4-phase req/ack register bus and the pad interface block.
- Provides synchronized input readback and per-pin edge-triggered interrupts.
- All state is in one clock domain; only `gpio_data_in` is treated as asynchronous.

Parameters:
- `WIDTH`, 32, number of GPIO pins (1..32); register bits above `WIDTH` read 0 and ignore writes.
- `ADDR_W`, 4, word-address width of the register bus.

Ports:
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `bus_req`  in  1  transaction request; held high until `bus_ack` seen, then dropped.
- `bus_we`  in  1  1 = write, 0 = read; stable while `bus_req` high.
- `bus_addr`  in  `ADDR_W`  word address; stable while `bus_req` high.
- `bus_wdata`  in  32  write data; stable while `bus_req` high.
- `bus_rdata`  out  32  read data; valid while `bus_ack` high.
- `bus_ack`  out  1  completion; high from ACK entry until `bus_req` low.
- `bus_err`  out  1  high with `bus_ack` for an unmapped address.
- `gpio_data_out`  out  `WIDTH`  to pad interface, output data.
- `gpio_oe`  out  `WIDTH`  to pad interface, 1 = drive pad.
- `gpio_data_in`  in  `WIDTH`  from pad interface; asynchronous.
- `irq`  out  1  level interrupt = OR of (`IRQ_STATUS` & `IRQ_EN`).

Behaviour:
Register map (word address):
- 0 `DATA_OUT` RW
- 1 `OE` RW
- 2 `DATA_IN` RO; writes are ignored, no error
- 3 `IRQ_EN` RW
- 4 `IRQ_TYPE` RW; 1 = rising, 0 = falling
- 5 `IRQ_STATUS` RW1C
- Any other address is unmapped.

Reset:
- Every register, the synchronizer flops and the FSM clear to 0 / IDLE.
- `bus_ack`, `bus_err`, `bus_rdata`, `irq` and all `gpio_*` outputs are 0.
- Reset mid-transaction aborts it: the pending write is not committed and `bus_ack` drops in the next cycle.

FSM (IDLE, ACCESS, ACK):
- IDLE: `bus_req` = 1 → ACCESS.
- ACCESS:
  - a write commits `bus_wdata` to the addressed register;
  - a read captures the register into the `bus_rdata` flop;
  - `bus_err` is computed;
  - always → ACK.
- ACK: `bus_ack` = 1; `bus_rdata` and `bus_err` are held.
  - `bus_req` = 0 → IDLE, clearing `bus_ack`, `bus_err` and `bus_rdata` to 0.
  - otherwise stay in ACK.
- Latency: `bus_req` rising at edge N gives `bus_ack` high after edge N+2.
- A written value appears on `gpio_data_out` / `gpio_oe` after edge N+1.
- Back-to-back transactions need at least one IDLE cycle.

Input path:
- 2-flop synchronizer `sync` is followed by a `prev` flop.
- `DATA_IN` reads `sync`, so pad-to-readable latency is 2 edges.
- rise[i] = `sync`[i] & ~`prev`[i]; fall[i] = ~`sync`[i] & `prev`[i].
- edge[i] = `IRQ_TYPE`[i] ? rise[i] : fall[i].

Interrupt status:
- `IRQ_STATUS`[i] is set when edge[i] & `IRQ_EN`[i].
- A W1C write clears the bits written as 1.
- Simultaneous set and clear on the same bit: set wins.
- Changing `IRQ_TYPE` or `IRQ_EN` does not alter existing status bits.
- `irq` is registered from the status and enable flops and updates 1 edge after status changes.

Optional Feature:
- Macro `GPIO_ATOMIC_SETCLR_EN`.
- Defined: adds write-only address 6 `DATA_SET` and address 7 `DATA_CLR`.
  - `DATA_SET`: `DATA_OUT` |= wdata.
  - `DATA_CLR`: `DATA_OUT` &= ~wdata.
  - Reads of 6 and 7 return 0 with no error.
- Undefined: addresses 6 and 7 are unmapped and give `bus_err`.

Decomposition:
- Package `gpio_pkg`:
  - register address localparams `GPIO_ADDR_DATA_OUT` … `GPIO_ADDR_DATA_CLR`;
  - FSM state typedef `gpio_ctrl_state_t` (IDLE, ACCESS, ACK);
  - `GPIO_MAX_WIDTH` = 32.
- Sub-module `gpio_in_sync` (`WIDTH`): holds the 2-flop synchronizer plus `prev` flop and outputs `sync`, `rise` and `fall`.

Test Plan:
- Reset check: hold `sys_rst` = 1 for 2 edges → all outputs 0. Read addr 0..5 → 0, `bus_err` = 0.
- Write addr 0 = 0xA5A5A5A5 and addr 1 = 0xFFFFFFFF:
  - `bus_ack` 2 edges after req;
  - `gpio_data_out` = 0xA5A5A5A5, `gpio_oe` = 0xFFFFFFFF;
  - readback matches.
- Drive `gpio_data_in` = 0x12345678:
  - read of addr 2 two or more edges later returns 0x12345678;
  - write of 0xFFFF to addr 2 leaves the value unchanged with no error.
- IRQ rising:
  - setup: `IRQ_EN` = 0x1, `IRQ_TYPE` = 0x1; pin0 goes 0→1;
  - status bit0 = 1 and `irq` = 1;
  - W1C 0x1 → status = 0 and `irq` = 0;
  - pin0 goes 1→0 → no new status.
- Simultaneous event: a rising edge on pin0 in the same edge as a W1C of bit0 → bit0 stays 1.
- Error path: access addr 0xF → `bus_ack` = 1, `bus_err` = 1, rdata = 0, no register change.
- Macro test (with macro): `DATA_OUT` = 0xF0, SET 0x0F gives 0xFF, CLR 0x81 gives 0x7E.
